// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller: FSM states,
// major opcodes and the ALUOp codes handed to the ALU control unit.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/main_ctrl_decode.sv
// Classifies the latched opcode into the instruction classes the controller sequences.
module main_ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic       is_r_o,
    output logic       is_ld_o,
    output logic       is_sd_o,
    output logic       is_beq_o,
    output logic       is_bad_o
);

    assign is_r_o   = (op_i == OP_R);
    assign is_ld_o  = (op_i == OP_LD);
    assign is_sd_o  = (op_i == OP_SD);
    assign is_beq_o = (op_i == OP_BEQ);
    assign is_bad_o = !(is_r_o || is_ld_o || is_sd_o || is_beq_o);

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB with memory-wait timeout.
// Optional ILLEGAL_OP_TRAP_EN: unknown opcodes park in TRAP and raise illegal.
module main_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [3:0] alu_func,
    output logic       alu_src,
    output logic       pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [2:0] state,
    output logic       bus_err
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegal
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0]       op_q, op_d;
    logic [3:0]       func_q, func_d;
    logic             is_r, is_ld, is_sd, is_beq, is_bad;
    logic             timeout;

    main_ctrl_decode u_decode (
        .op_i     (op_q),
        .is_r_o   (is_r),
        .is_ld_o  (is_ld),
        .is_sd_o  (is_sd),
        .is_beq_o (is_beq),
        .is_bad_o (is_bad)
    );

    // Expiry wins only when memory is still not ready in the same cycle.
    assign timeout = (wait_cnt_q == CNT_W'(MEM_WAIT_MAX)) && !mem_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        op_d       = op_q;
        func_d     = func_q;
        alu_op     = ALUOP_ADD;
        alu_src    = 1'b0;
        pc_src     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        bus_err    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal    = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                if (timeout) begin
                    bus_err    = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            DECODE: begin
                op_d    = opcode;
                func_d  = {funct7_5, funct3};
                state_d = EXEC;
            end
            EXEC: begin
                if (is_r) begin
                    alu_op  = ALUOP_RTYPE;
                    state_d = WB;
                end else if (is_ld || is_sd) begin
                    alu_src = 1'b1;
                    state_d = MEM;
                end else if (is_beq) begin
                    alu_op   = ALUOP_SUB;
                    pc_src   = 1'b1;
                    pc_write = zero;
                    state_d  = FETCH;
                end else if (is_bad) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = TRAP;
`else
                    state_d = FETCH;
`endif
                end
            end
            MEM: begin
                // An expired store drops its write strobe so no late write escapes.
                if (timeout) begin
                    bus_err = 1'b1;
                    state_d = FETCH;
                end else begin
                    mem_read  = is_ld;
                    mem_write = is_sd;
                    if (mem_ready) begin
                        state_d = is_ld ? WB : FETCH;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                state_d    = FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: begin
                illegal = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase

        if (state_d != state_q) wait_cnt_d = '0;

        // Everything visible is held quiet while reset is asserted.
        if (rst) begin
            alu_op     = 2'b00;
            alu_src    = 1'b0;
            pc_src     = 1'b0;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            bus_err    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal    = 1'b0;
`endif
        end
    end

    assign state    = rst ? 3'd0 : state_q;
    assign alu_func = rst ? 4'd0 : func_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            op_q       <= '0;
            func_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            func_q     <= func_d;
        end
    end

endmodule
